// File: rtl/mcpu_program_loader.sv
// mcpu_program_loader: boot-time loader for the MCPU instruction RAM.
// Accepts a byte-stream image (COUNT, N big-endian words, checksum byte),
// writes the words to consecutive RAM addresses and releases the CPU from
// reset only after the XOR checksum over the image matches.
module mcpu_program_loader #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 8,
  parameter int RAM_SIZE  = 256
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 mem_we,
  output logic [ADDR_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 cpu_reset,
  output logic                 done,
  output logic                 error
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CHECK = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  // Running XOR checksum: fold one more image byte into the accumulator.
  function automatic logic [7:0] csum_update(input logic [7:0] acc,
                                             input logic [7:0] b);
    return acc ^ b;
  endfunction

  state_t                 state_r;
  state_t                 next_state_s;
  logic                   in_ready_s;
  logic                   xfer_s;
  logic [7:0]             csum_r;
  logic [7:0]             hi_r;
  logic [ADDR_SIZE-1:0]   count_r;
  logic [ADDR_SIZE-1:0]   idx_r;
  logic                   mem_we_r;
  logic [ADDR_SIZE-1:0]   mem_addr_r;
  logic [WORD_SIZE-1:0]   mem_wdata_r;
  logic                   cpu_reset_r;
  logic                   done_r;
  logic                   error_r;

  // The loader takes bytes only in the byte-consuming states, never in WRITE.
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      S_COUNT, S_HI, S_LO, S_CHECK: in_ready_s = 1'b1;
      default:                      in_ready_s = 1'b0;
    endcase
  end

  assign xfer_s = in_valid & in_ready_s;

  // Next-state logic; start is honoured only in the resting states.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) next_state_s = S_COUNT;
        else       next_state_s = state_r;
      end
      S_COUNT: begin
        if (xfer_s) next_state_s = S_HI;
        else        next_state_s = S_COUNT;
      end
      S_HI: begin
        if (xfer_s) next_state_s = S_LO;
        else        next_state_s = S_HI;
      end
      S_LO: begin
        if (xfer_s) next_state_s = S_WRITE;
        else        next_state_s = S_LO;
      end
      S_WRITE: begin
        if (idx_r == count_r) next_state_s = S_CHECK;
        else                  next_state_s = S_HI;
      end
      S_CHECK: begin
        if (xfer_s) begin
          if (in_data == csum_r) next_state_s = S_DONE;
          else                   next_state_s = S_ERR;
        end else begin
          next_state_s = S_CHECK;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= S_IDLE;
    else       state_r <= next_state_s;
  end

  // Datapath: checksum, word count, word index, high byte and RAM address/data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum_r      <= 8'd0;
      hi_r        <= 8'd0;
      count_r     <= {ADDR_SIZE{1'b0}};
      idx_r       <= {ADDR_SIZE{1'b0}};
      mem_addr_r  <= {ADDR_SIZE{1'b0}};
      mem_wdata_r <= {WORD_SIZE{1'b0}};
    end else begin
      case (state_r)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            csum_r <= 8'd0;
            idx_r  <= {ADDR_SIZE{1'b0}};
          end
        end
        S_COUNT: begin
          if (xfer_s) begin
            count_r <= ADDR_SIZE'(in_data);
            csum_r  <= csum_update(csum_r, in_data);
          end
        end
        S_HI: begin
          if (xfer_s) begin
            hi_r   <= in_data;
            csum_r <= csum_update(csum_r, in_data);
          end
        end
        S_LO: begin
          // Word address/data are captured here so they are stable during WRITE.
          if (xfer_s) begin
            csum_r      <= csum_update(csum_r, in_data);
            mem_addr_r  <= idx_r;
            mem_wdata_r <= WORD_SIZE'({hi_r, in_data});
          end
        end
        S_WRITE: begin
          // Index stops at the last word so it never wraps past the RAM top.
          if (idx_r != count_r) idx_r <= idx_r + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs are registered from the next state so they track the state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_we_r    <= 1'b0;
      cpu_reset_r <= 1'b1;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      mem_we_r    <= (next_state_s == S_WRITE);
      cpu_reset_r <= (next_state_s != S_DONE);
      done_r      <= (next_state_s == S_DONE);
      error_r     <= (next_state_s == S_ERR);
    end
  end

  assign in_ready  = in_ready_s;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign cpu_reset = cpu_reset_r;
  assign done      = done_r;
  assign error     = error_r;

endmodule

// File: tb/tb_mcpu_program_loader.sv
// Scoreboard bench for mcpu_program_loader: the image model pushes expected
// RAM writes and the final verdict; a negedge monitor pops and compares.
module tb_mcpu_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_reset;
  logic        done;
  logic        error;

  mcpu_program_loader #(.WORD_SIZE(16), .ADDR_SIZE(8), .RAM_SIZE(256)) dut (
    .clk(clk), .reset(reset), .start(start), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .cpu_reset(cpu_reset),
    .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          is_result;
    logic [7:0]  addr;
    logic [15:0] data;
    bit          ok;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          n_writes = 0;
  bit          prev_flag = 1'b0;
  logic [15:0] img_words [256];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h, required %h at %0t", name, act, expv, $time);
  endtask

  task automatic fail_now(input string name, input string what);
    n_checks++;
    $display("FAIL %s: %s at %0t", name, what, $time);
  endtask

  // Monitor: invariants every cycle, plus scoreboard pops on writes and verdicts.
  always @(negedge clk) begin
    check("inv_done_and_error", {31'd0, done & error}, 32'd0);
    check("inv_cpu_reset_vs_done", {31'd0, cpu_reset}, {31'd0, ~done});
    if (mem_we) begin
      n_writes++;
      check("in_ready_in_write", {31'd0, in_ready}, 32'd0);
      if (exp_q.size() == 0 || exp_q[0].is_result) begin
        fail_now("unexpected_write", $sformatf("got addr %h data %h, required no write", mem_addr, mem_wdata));
      end else begin
        mon_e = exp_q.pop_front();
        check("write_addr", {24'd0, mem_addr}, {24'd0, mon_e.addr});
        check("write_data", {16'd0, mem_wdata}, {16'd0, mon_e.data});
      end
    end
    if ((done | error) && !prev_flag) begin
      if (exp_q.size() == 0 || !exp_q[0].is_result) begin
        fail_now("unexpected_verdict", $sformatf("got done=%b error=%b, required pending writes", done, error));
      end else begin
        mon_e = exp_q.pop_front();
        check("verdict_done", {31'd0, done}, {31'd0, mon_e.ok});
        check("verdict_error", {31'd0, error}, {31'd0, !mon_e.ok});
      end
    end
    prev_flag = done | error;
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("after_start_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("after_start_done", {31'd0, done}, 32'd0);
    check("after_start_error", {31'd0, error}, 32'd0);
  endtask

  // Offer one byte until it is accepted; pct is the chance in_valid is high.
  task automatic send_byte(input logic [7:0] b, input int pct);
    bit sent = 1'b0;
    int cyc = 0;
    while (!sent && cyc < 300) begin
      if ($urandom_range(0, 99) < pct) begin
        in_valid = 1'b1;
        in_data  = b;
      end else begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end
      @(negedge clk);
      sent = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    if (!sent) fail_now("send_timeout", $sformatf("byte %h never accepted", b));
  endtask

  task automatic wait_verdict();
    int cyc = 0;
    while (!(done | error) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!(done | error)) fail_now("verdict_timeout", "neither done nor error");
    @(negedge clk); #1;
    check("queue_drained", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  // Reference: image = C, words hi/lo, K = XOR of everything before it.
  task automatic run_load(input int c, input bit corrupt, input int pct, input int start_at);
    logic [7:0] bytes[$];
    logic [7:0] k;
    exp_t e;
    bytes.push_back(8'(c));
    for (int i = 0; i <= c; i++) begin
      bytes.push_back(img_words[i][15:8]);
      bytes.push_back(img_words[i][7:0]);
    end
    k = 8'd0;
    foreach (bytes[j]) k = k ^ bytes[j];
    if (corrupt) k = k ^ 8'h01;
    bytes.push_back(k);
    for (int i = 0; i <= c; i++) begin
      e.is_result = 1'b0; e.addr = 8'(i); e.data = img_words[i]; e.ok = 1'b0;
      exp_q.push_back(e);
    end
    e.is_result = 1'b1; e.addr = 8'd0; e.data = 16'd0; e.ok = !corrupt;
    exp_q.push_back(e);
    pulse_start();
    for (int j = 0; j < bytes.size(); j++) begin
      if (j == start_at) start = 1'b1;
      send_byte(bytes[j], pct);
      start = 1'b0;
    end
    wait_verdict();
  endtask

  task automatic set_nominal();
    img_words[0] = 16'h1420;
    img_words[1] = 16'h150C;
    img_words[2] = 16'h2D45;
  endtask

  initial begin
    exp_t e;
    int base;
    int cyc;
    #1 reset = 1'b1;
    @(posedge clk); #1;
    check("reset_in_ready", {31'd0, in_ready}, 32'd0);
    check("reset_mem_we", {31'd0, mem_we}, 32'd0);
    check("reset_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("reset_mem_wdata", {16'd0, mem_wdata}, 32'd0);
    check("reset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_error", {31'd0, error}, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Nominal, bad checksum, then restart from ERR with the good image.
    set_nominal(); run_load(2, 1'b0, 100, -1);
    set_nominal(); run_load(2, 1'b1, 100, -1);
    set_nominal(); run_load(2, 1'b0, 100, -1);
    // Random source stalls.
    set_nominal(); run_load(2, 1'b0, 50, -1);
    // Single word.
    img_words[0] = 16'hABCD; run_load(0, 1'b0, 100, -1);
    // start while in LO (byte 2 is word 0 low byte) is ignored.
    set_nominal(); run_load(2, 1'b0, 100, 2);
    // Random images.
    for (int t = 0; t < 4; t++) begin
      int c;
      c = $urandom_range(0, 20);
      for (int i = 0; i <= c; i++) img_words[i] = 16'($urandom);
      run_load(c, ($urandom_range(0, 3) == 0), $urandom_range(30, 100), -1);
    end
    // Full RAM.
    for (int i = 0; i < 256; i++) img_words[i] = 16'(i * 16'h0101);
    run_load(255, 1'b0, 100, -1);

    // Reset mid-load after the second word is written.
    for (int i = 0; i < 6; i++) img_words[i] = 16'($urandom);
    for (int i = 0; i < 2; i++) begin
      e.is_result = 1'b0; e.addr = 8'(i); e.data = img_words[i]; e.ok = 1'b0;
      exp_q.push_back(e);
    end
    base = n_writes;
    pulse_start();
    send_byte(8'd5, 100);
    for (int i = 0; i < 2; i++) begin
      send_byte(img_words[i][15:8], 100);
      send_byte(img_words[i][7:0], 100);
    end
    cyc = 0;
    while (n_writes < base + 2 && cyc < 10) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("midload_writes_seen", n_writes - base, 32'd2);
    #2 reset = 1'b1;
    #1;
    check("midreset_mem_we", {31'd0, mem_we}, 32'd0);
    check("midreset_cpu_reset", {31'd0, cpu_reset}, 32'd1);
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_error", {31'd0, error}, 32'd0);
    check("midreset_in_ready", {31'd0, in_ready}, 32'd0);
    check("midreset_queue", exp_q.size(), 32'd0);
    exp_q.delete();
    @(posedge clk); #3 reset = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'($urandom);
      @(negedge clk);
      check("post_reset_ignores_bytes", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    set_nominal(); run_load(2, 1'b0, 100, -1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
